// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, ld_op bit positions and the execute-to-memory bus layout
package mem_stage_pkg;
   localparam int ES_TO_MS_BUS_WD = 76;
   localparam int MS_TO_WS_BUS_WD = 70;
   localparam int MS_FWD_BUS_WD   = 38;
   localparam int LD_W  = 0;
   localparam int LD_HU = 1;
   localparam int LD_H  = 2;
   localparam int LD_BU = 3;
   localparam int LD_B  = 4;
   typedef struct packed {
      logic [4:0]  ld_op;
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
   } es_to_ms_t;
endpackage

// File: rtl/mem_stage_align.sv
// load_align: picks the addressed byte/halfword from the read word and extends it
module load_align
   import mem_stage_pkg::*;
(
   input  logic [4:0]  ld_op,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   output logic [31:0] data
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b = rdata[{addr, 3'b000} +: 8];
      h = rdata[{addr[1], 4'b0000} +: 16];
      // anything that is not a byte/halfword load (ld_w or all-zero) passes the word through
      data = ld_op[LD_B]  ? {{24{b[7]}}, b}  :
             ld_op[LD_BU] ? {24'b0, b}       :
             ld_op[LD_H]  ? {{16{h[15]}}, h} :
             ld_op[LD_HU] ? {16'b0, h}       : rdata;
   end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage; aligns load data and holds it across write-back stalls
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic [31:0]                data_sram_rdata,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);
   es_to_ms_t   bus_q, bus_d;
   logic        ms_valid_q, ms_valid_d;
   logic        first_cycle_q, first_cycle_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] rdata_buf_q, rdata_buf_d;
   logic [31:0] mem_rdata, ld_data, final_result;
   logic        accept, buf_cap;

   load_align u_align (
      .ld_op (bus_q.ld_op),
      .addr  (bus_q.result[1:0]),
      .rdata (mem_rdata),
      .data  (ld_data)
   );

   always_comb begin
      ms_allowin    = !ms_valid_q || ws_allowin;
      accept        = es_to_ms_valid && ms_allowin;
      ms_valid_d    = ms_allowin ? es_to_ms_valid : ms_valid_q;
      bus_d         = accept ? es_to_ms_t'(es_to_ms_bus) : bus_q;
      first_cycle_d = accept;
      // SRAM data is only ours in the first cycle; keep it if write-back is stalling
      buf_cap       = ms_valid_q && first_cycle_q && bus_q.res_from_mem && !ws_allowin;
      buf_valid_d   = (ms_valid_q && ws_allowin) ? 1'b0 : buf_cap ? 1'b1 : buf_valid_q;
      rdata_buf_d   = buf_cap ? data_sram_rdata : rdata_buf_q;
      mem_rdata     = buf_valid_q ? rdata_buf_q : data_sram_rdata;
      final_result  = bus_q.res_from_mem ? ld_data : bus_q.result;
      ms_to_ws_valid = ms_valid_q;
      ms_to_ws_bus  = {bus_q.gr_we, bus_q.dest, final_result, bus_q.pc};
      ms_fwd_bus    = {ms_valid_q && bus_q.gr_we, bus_q.dest, final_result};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid_q    <= 1'b0;
         first_cycle_q <= 1'b0;
         buf_valid_q   <= 1'b0;
      end else begin
         ms_valid_q    <= ms_valid_d;
         first_cycle_q <= first_cycle_d;
         buf_valid_q   <= buf_valid_d;
      end
      bus_q       <= bus_d;
      rdata_buf_q <= rdata_buf_d;
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors with a scoreboard queue checked by a monitor on the falling edge
module tb_mem_stage;
   logic        clk = 0, reset = 1, ws_allowin = 0, es_to_ms_valid = 0;
   logic [75:0] es_to_ms_bus = '0;
   logic [31:0] data_sram_rdata = '0;
   logic        ms_allowin, ms_to_ws_valid;
   logic [69:0] ms_to_ws_bus;
   logic [37:0] ms_fwd_bus;
   int          checks = 0, failures = 0;
   logic [69:0] q[$];
   logic [31:0] pend_rd = '0;
   logic [31:0] pc = 32'h1000;
   logic [75:0] nx;

   localparam logic [4:0] OP_B = 5'b10000, OP_BU = 5'b01000, OP_H = 5'b00100,
                          OP_HU = 5'b00010, OP_W = 5'b00001;

   mem_stage dut (
      .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
      .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
      .data_sram_rdata(data_sram_rdata), .ms_to_ws_valid(ms_to_ws_valid),
      .ms_to_ws_bus(ms_to_ws_bus), .ms_fwd_bus(ms_fwd_bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [75:0] mk(input logic [4:0] op, input logic rfm, input logic we,
                                      input logic [4:0] d, input logic [31:0] res, input logic [31:0] p);
      return {op, rfm, we, d, res, p};
   endfunction

   task automatic step(input logic v, input logic [75:0] b, input logic [31:0] rd, input logic wsa);
      es_to_ms_valid = v; es_to_ms_bus = b; data_sram_rdata = rd; ws_allowin = wsa;
      @(posedge clk); #1;
   endtask

   task automatic ld(input logic [4:0] op, input logic [1:0] a, input logic we,
                     input logic [4:0] d, input logic [31:0] rd, input logic [31:0] exp);
      q.push_back({we, d, exp, pc});
      step(1'b1, mk(op, 1'b1, we, d, {30'h2000_0000, a}, pc), pend_rd, 1'b1);
      pend_rd = rd;
      pc += 4;
   endtask

   task automatic alu(input logic we, input logic [4:0] d, input logic [31:0] res);
      q.push_back({we, d, res, pc});
      step(1'b1, mk(5'b0, 1'b0, we, d, res, pc), pend_rd, 1'b1);
      pend_rd = '0;
      pc += 4;
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (ms_to_ws_valid) begin
            if (q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_output actual=%h expected=none", ms_to_ws_bus);
            end else begin
               chk("ws_bus", ms_to_ws_bus, q[0]);
               chk("fwd_bus", 70'(ms_fwd_bus), 70'(q[0][69:32]));
               if (ws_allowin) void'(q.pop_front());
            end
         end else
            chk("fwd_idle", 70'(ms_fwd_bus[37]), 70'(0));
      end
   end

   initial begin
      step(1'b0, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b0);
      chk("rst_valid", 70'(ms_to_ws_valid), 70'(0));
      chk("rst_fwd_valid", 70'(ms_fwd_bus[37]), 70'(0));
      chk("rst_allowin", 70'(ms_allowin), 70'(1));
      reset = 0;
      step(1'b0, '0, '0, 1'b1);
      alu(1'b1, 5'd5, 32'h1234_5678);
      alu(1'b0, 5'd6, 32'h0BAD_0001);
      ld(OP_B,  2'd2, 1'b1, 5'd7,  32'h0080_0000, 32'hFFFF_FF80);
      ld(OP_BU, 2'd2, 1'b1, 5'd8,  32'h0080_0000, 32'h0000_0080);
      ld(OP_H,  2'd2, 1'b1, 5'd9,  32'h8001_1234, 32'hFFFF_8001);
      ld(OP_HU, 2'd0, 1'b1, 5'd10, 32'h8001_1234, 32'h0000_1234);
      ld(OP_B,  2'd3, 1'b1, 5'd11, 32'h7F00_0000, 32'h0000_007F);
      ld(OP_BU, 2'd1, 1'b1, 5'd12, 32'h0000_AB00, 32'h0000_00AB);
      ld(OP_HU, 2'd3, 1'b1, 5'd13, 32'hBEEF_0000, 32'h0000_BEEF);
      ld(OP_B,  2'd0, 1'b0, 5'd14, 32'h0000_00FF, 32'hFFFF_FFFF);
      ld(5'b0,  2'd1, 1'b1, 5'd15, 32'hCAFE_F00D, 32'hCAFE_F00D);
      ld(OP_W,  2'd0, 1'b1, 5'd16, 32'h0000_000A, 32'h0000_000A);
      ld(OP_W,  2'd0, 1'b1, 5'd17, 32'h0000_000B, 32'h0000_000B);
      step(1'b0, '0, pend_rd, 1'b1);
      // write-back stalls 3 cycles while execute offers a new instruction and the SRAM data changes
      ld(OP_W, 2'd0, 1'b1, 5'd18, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      nx = mk(5'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0055, pc);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, nx, i == 0 ? pend_rd : 32'h1111_1111, 1'b0);
         chk("stall_allowin", 70'(ms_allowin), 70'(0));
      end
      q.push_back({1'b1, 5'd3, 32'h0000_0055, pc});
      pc += 4;
      step(1'b1, nx, 32'h1111_1111, 1'b1);
      step(1'b0, '0, '0, 1'b1);
      pend_rd = '0;
      // reset while a buffered load is stalled
      ld(OP_W, 2'd0, 1'b1, 5'd20, 32'h0BAD_F00D, 32'h0BAD_F00D);
      step(1'b0, '0, pend_rd, 1'b0);
      step(1'b0, '0, 32'h7777_7777, 1'b0);
      reset = 1;
      step(1'b0, '0, 32'h7777_7777, 1'b0);
      q.delete();
      chk("midrst_valid", 70'(ms_to_ws_valid), 70'(0));
      chk("midrst_fwd_valid", 70'(ms_fwd_bus[37]), 70'(0));
      chk("midrst_allowin", 70'(ms_allowin), 70'(1));
      reset = 0;
      pend_rd = '0;
      ld(OP_W, 2'd0, 1'b1, 5'd21, 32'h2468_ACE0, 32'h2468_ACE0);
      step(1'b0, '0, pend_rd, 1'b1);
      step(1'b0, '0, '0, 1'b1);
      step(1'b0, '0, '0, 1'b1);
      chk("queue_drained", 70'(q.size()), 70'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of write-back. It consumes the execute-to-memory bus and the synchronous data SRAM read data, which arrives one cycle after execute issues the request. It aligns and extends load data, and holds that data safely across write-back stalls. It then produces the memory-to-write-back bus and a forwarding bus for decode.

Parameters:
None. All bus widths come from shared header macros.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ws_allowin  in  1  write-back can accept this cycle
ms_allowin  out  1  this stage can accept this cycle
es_to_ms_valid  in  1  execute has a valid instruction
es_to_ms_bus  in  76  {ld_op[4:0]=ld_b,ld_bu,ld_h,ld_hu,ld_w; res_from_mem; gr_we; dest[4:0]; result[31:0]; pc[31:0]}
data_sram_rdata  in  32  SRAM read data; valid the cycle after execute asserted data_sram_en
ms_to_ws_valid  out  1  valid instruction to write-back
ms_to_ws_bus  out  70  {gr_we; dest[4:0]; final_result[31:0]; pc[31:0]}
ms_fwd_bus  out  38  {fwd_valid; dest[4:0]; final_result[31:0]}

Behaviour:
- Reset (synchronous, active-high, clock clk): ms_valid=0, first_cycle=0, buf_valid=0. Output values after reset:
  - ms_to_ws_valid=0, fwd_valid=0, ms_allowin=1.
  - Bus payload registers are not reset; their contents are don't-care while valid=0.
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_to_ws_valid = ms_valid.
- Valid update: when ms_allowin, ms_valid <= es_to_ms_valid.
- Payload capture: es_to_ms_bus is registered only when es_to_ms_valid && ms_allowin.
- first_cycle: set to 1 on accept, cleared the following cycle. It marks the only cycle in which data_sram_rdata belongs to this instruction.
- Read-data buffer:
  - Capture: if ms_valid && first_cycle && res_from_mem && !ws_allowin, then rdata_buf <= data_sram_rdata and buf_valid <= 1.
  - Hold: buf_valid stays 1 for the rest of the stall.
  - Clear: buf_valid clears when the instruction leaves (ms_valid && ws_allowin) or on reset.
  - Rationale: execute may issue a new SRAM access while this stage is stalled, which overwrites rdata.
- Read-data select: mem_rdata = buf_valid ? rdata_buf : data_sram_rdata.
- Load alignment, using addr = result[1:0]:
  - ld_b / ld_bu: take byte mem_rdata[8*addr +: 8], then sign- or zero-extend.
  - ld_h / ld_hu: take halfword mem_rdata[16*addr[1] +: 16]. addr[0] is ignored; misalignment is not checked here.
  - ld_w: take mem_rdata unchanged.
  - ld_op is one-hot. An all-zero ld_op with res_from_mem=1 is treated as ld_w.
- final_result = res_from_mem ? aligned load data : result.
- Forwarding: fwd_valid = ms_valid && gr_we. The forwarded value is the final_result, load data included, so decode needs no load-use stall on a memory-stage hit.
- Back-to-back: accepting a new instruction in the same cycle the old one leaves is allowed. first_cycle is set again, and buf_valid is cleared because the old instruction left.
- Reset mid-stall: the buffered data and the instruction are discarded.

Decomposition:
- mycpu.h defines:
  - ES_TO_MS_BUS_WD=76
  - MS_TO_WS_BUS_WD=70
  - MS_FWD_BUS_WD=38
  - ld_op bit-index constants
- Sub-module load_align: combinational; inputs ld_op, addr[1:0], rdata; output extended data.
- The stage register, first_cycle, and buffer logic stay in mem_stage.

Test Plan:
- Non-load passthrough: gr_we=1, dest=5, result=0x1234_5678, ws_allowin=1 -> next cycle ms_to_ws_bus carries final_result=0x1234_5678; fwd_valid=1 with dest=5.
- Load byte signed and unsigned: ld_b, addr=2, rdata=0x0080_0000 -> 0xFFFF_FF80. Same with ld_bu -> 0x0000_0080.
- Load halfword: ld_h, addr=2, rdata=0x8001_1234 -> 0xFFFF_8001. ld_hu, addr=0 -> 0x0000_1234.
- Stall hold: ld_w accepted with rdata=0xDEAD_BEEF, ws_allowin=0 for 3 cycles, rdata changes to 0x1111_1111 the next cycle -> final_result stays 0xDEAD_BEEF; ms_allowin=0; released on the 4th cycle.
- Back-to-back loads, no stall: rdata 0xA, 0xB on consecutive cycles -> write-back sees 0xA then 0xB, and buf_valid never set.
- Reset mid-stall: assert reset with buf_valid=1 -> next cycle ms_to_ws_valid=0, fwd_valid=0, ms_allowin=1.
